priority_scan_display: RTL and testbench
========================================

PRIORITY_SCAN_DISPLAY -- requirements
Module: priority_scan_display

Interface
REQ-001 Parameter WIDTH, default 16, number of data bits; legal range 2..256.
REQ-002 Parameter PRESCALE, default 1000, clock cycles per displayed digit; legal range 1..65535.
REQ-003 Derived constant IDX_W = max(1, ceil(log2(WIDTH))).
REQ-004 Derived constant DIGITS = ceil(IDX_W/4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 data  input  WIDTH  request bits; bit WIDTH-1 is the most significant.
REQ-008 sample  input  1  capture strobe, one capture per cycle asserted.
REQ-009 mode  input  1  0 = report highest set bit index; 1 = report lowest set bit index.
REQ-010 hold  input  1  1 = ignore sample and freeze the result.
REQ-011 index  output  IDX_W  registered encoded result.
REQ-012 valid  output  1  registered; 1 = at least one bit was set in the last evaluated capture.
REQ-013 segments  output  7  active-high segment drive, bit order gfedcba, for the selected digit.
REQ-014 dp  output  1  decimal point; 1 = no bit set (none indicator).
REQ-015 digit_en  output  DIGITS  one-hot active-high digit select; bit 0 = least significant hex digit.

Function
REQ-016 Capture: at a rising edge with sample=1, hold=0 and rst=0, data and mode SHALL be loaded into internal registers data_q and mode_q.
REQ-017 Evaluate: at the edge after a capture, index, valid and the internal none flag SHALL update from data_q and mode_q, giving 2-cycle latency from sample to output.
REQ-018 Back-to-back samples on consecutive cycles SHALL each produce a result, pipelined at one result per cycle.
REQ-019 mode=0: index = position of the highest set bit of data_q; mode=1: index = position of the lowest set bit.
REQ-020 A mode change without a sample SHALL NOT change index.
REQ-021 data_q = 0: index SHALL be 0, valid SHALL be 0 and none SHALL be 1.
REQ-022 hold=1: sample SHALL be ignored; data_q, index, valid and none SHALL hold; digit scanning SHALL continue.
REQ-023 A capture accepted in cycle N-1 with hold asserted in cycle N SHALL still be evaluated at edge N.
REQ-024 Prescaler: a counter SHALL count 0..PRESCALE-1; on reaching PRESCALE-1 it SHALL wrap to 0 and the digit pointer SHALL advance, wrapping from DIGITS-1 to 0.
REQ-025 With DIGITS=1 the pointer SHALL stay 0 and digit_en SHALL be constantly 1.
REQ-026 digit_en SHALL equal the one-hot of the digit pointer.
REQ-027 segments SHALL show the hex glyph of nibble[pointer] of index, zero-extended to 4*DIGITS bits.
REQ-028 Hex glyphs (gfedcba): 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110, 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111, A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001.
REQ-029 When none=1: segments SHALL be 0000000 on every digit and dp SHALL be 1; otherwise dp SHALL be 0.
REQ-030 segments, dp and digit_en SHALL depend only on registered state, with no combinational path from any input.

Reset
REQ-031 rst=1 at an edge SHALL set data_q=0, mode_q=0, index=0, valid=0, none=1, prescaler=0 and pointer=0.
REQ-032 After reset: segments=0000000, dp=1, digit_en=1 (only bit 0 set).
REQ-033 Reset SHALL take priority over sample and hold in the same cycle; no capture occurs.
REQ-034 rst=1 SHALL discard any capture in flight; the first result after reset comes from a new sample.

Verification
REQ-035 Reset, then data=0 with sample for 1 cycle -> from 2 edges later: valid=0, index=0, dp=1, segments=0000000.
REQ-036 WIDTH=32, mode=0, data=0x80000001, sample -> index=31 (0x1F); digit0 segments=1110001 (F), digit1 segments=0000110 (1); repeat with mode=1 -> index=0, valid=1.
REQ-037 WIDTH=16, data=0x0040 sampled, then hold=1 with data=0x8000 and sample=1 for 5 cycles -> index stays 6, valid=1.
REQ-038 WIDTH=32, PRESCALE=4, 12 idle cycles after reset -> digit_en sequence 01 (4 cycles), 10 (4 cycles), 01 (4 cycles).
REQ-039 WIDTH=16, sample=1 on 3 consecutive cycles with data=0x0001, 0x0100, 0x8000 and mode=0 -> index 0, 8, 15 on 3 consecutive cycles starting 2 edges after the first sample.
REQ-040 rst=1 and sample=1 in the same cycle, with data=0xFFFF -> after that edge and the next: index=0, valid=0, dp=1.

Source files
------------

// File: rtl/priority_scan_display_if.sv
// ----------------------------------------------------------------------------
// priority_scan_display_if
//
// Purpose:
//   Bundles the request/strobe inputs and the encoded/display outputs of
//   priority_scan_display into a single interface.
//   The clock and reset are not part of it and stay scalar ports.
//
// Parameter:
//   WIDTH     number of request bits (2..256)
//
// Signals:
//   data      [WIDTH-1:0]   request bits, bit WIDTH-1 is the MSB
//   sample                  capture strobe
//   mode                    0 = highest set bit, 1 = lowest set bit
//   hold                    freeze result and ignore sample
//   index     [IDX_W-1:0]   registered encoded result
//   valid                   at least one bit set in last evaluated capture
//   segments  [6:0]         active-high segments, order gfedcba
//   dp                      decimal point, lit when no bit is set
//   digit_en  [DIGITS-1:0]  one-hot digit select, bit 0 = least significant
//
// Modports:
//   master    drives the inputs and observes the outputs (testbench side)
//   slave     the priority_scan_display side
// ----------------------------------------------------------------------------
interface priority_scan_display_if #(
  parameter int WIDTH = 16
);

  localparam int IDX_W  = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int DIGITS = (IDX_W + 3) / 4;

  logic [WIDTH-1:0]  data;
  logic              sample;
  logic              mode;
  logic              hold;
  logic [IDX_W-1:0]  index;
  logic              valid;
  logic [6:0]        segments;
  logic              dp;
  logic [DIGITS-1:0] digit_en;

  modport master (
    output data, sample, mode, hold,
    input  index, valid, segments, dp, digit_en
  );

  modport slave (
    input  data, sample, mode, hold,
    output index, valid, segments, dp, digit_en
  );

endinterface

// File: rtl/priority_scan_display.sv
// ----------------------------------------------------------------------------
// priority_scan_display
//
// Purpose:
//   Captures a request vector on a sample strobe, encodes the position of
//   the highest (mode=0) or lowest (mode=1) set bit, and shows the encoded
//   index as hex on a time-multiplexed 7-segment display.
//   From sample to a visible index there are two clock edges:
//     - one edge to capture the data;
//     - one edge to evaluate the captured data.
//   An all-zero capture lights only the decimal point ("none").
//
// Parameters:
//   WIDTH     request width (2..256)
//   PRESCALE  clock cycles each digit stays selected (1..65535)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       priority_scan_display_if.slave; carries:
//               - data, sample, mode, hold in;
//               - index, valid, segments, dp, digit_en out.
// ----------------------------------------------------------------------------
module priority_scan_display #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  priority_scan_display_if.slave  bus
);

  localparam int IDX_W  = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int DIGITS = (IDX_W + 3) / 4;
  localparam int PTR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [15:0]      PS_LAST  = 16'(PRESCALE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DIGITS - 1);

  // Capture stage
  logic [WIDTH-1:0]    r_data_q;
  logic                r_mode_q;
  logic                r_pend;

  // Result stage
  logic [IDX_W-1:0]    r_index;
  logic                r_valid;
  logic                r_none;

  // Display scanning
  logic [15:0]         r_presc;
  logic [PTR_W-1:0]    r_ptr;

  logic                w_capture;
  logic [IDX_W-1:0]    w_hi;
  logic [IDX_W-1:0]    w_lo;
  logic [4*DIGITS-1:0] w_idx_ext;
  logic [3:0]          w_nib;
  logic [6:0]          w_glyph;
  logic [DIGITS-1:0]   w_digit_en;

  // hold masks the strobe; only unmasked strobes load the capture registers.
  assign w_capture = bus.sample & ~bus.hold;

  // Priority encoders over the captured vector.
  // In the upward loop the last hit wins, which gives the highest set bit.
  // In the downward loop the last hit wins, which gives the lowest set bit.
  // Both give 0 for an all-zero vector.
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_data_q[i]) w_hi = IDX_W'(i);
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_data_q[i]) w_lo = IDX_W'(i);
    end
  end

  // Capture and evaluate pipeline.
  // r_pend marks that the capture registers were loaded at the previous
  // edge. Evaluation is keyed on r_pend rather than on hold, for two reasons:
  //   - a capture taken just before hold rises still lands in the result;
  //   - while held, no new capture is loaded, so the result freezes.
  // Reset clears r_pend, which drops any capture still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
      r_mode_q <= 1'b0;
      r_pend   <= 1'b0;
      r_index  <= '0;
      r_valid  <= 1'b0;
      r_none   <= 1'b1;
    end else begin
      if (w_capture) begin
        r_data_q <= bus.data;
        r_mode_q <= bus.mode;
      end
      r_pend <= w_capture;
      if (r_pend) begin
        r_index <= r_mode_q ? w_lo : w_hi;
        r_valid <= |r_data_q;
        r_none  <= ~(|r_data_q);
      end
    end
  end

  // Prescaler and digit pointer.
  // The pointer steps on the cycle the prescaler wraps.
  // With a single digit, PTR_LAST is 0, so the pointer never leaves 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_presc == PS_LAST) begin
        r_presc <= '0;
        r_ptr   <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  // Nibble selection.
  // The index is zero-extended to a whole number of nibbles, and the nibble
  // under the pointer is picked. Only registered state feeds this path.
  always_comb begin
    w_idx_ext              = '0;
    w_idx_ext[IDX_W-1:0]   = r_index;
    w_nib                  = 4'h0;
    w_digit_en             = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_ptr == PTR_W'(d)) begin
        w_nib         = w_idx_ext[4*d +: 4];
        w_digit_en[d] = 1'b1;
      end
    end
  end

  // Hex glyph table, bit order gfedcba, active high.
  always_comb begin
    w_glyph = 7'b0000000;
    case (w_nib)
      4'h0: w_glyph = 7'b0111111;
      4'h1: w_glyph = 7'b0000110;
      4'h2: w_glyph = 7'b1011011;
      4'h3: w_glyph = 7'b1001111;
      4'h4: w_glyph = 7'b1100110;
      4'h5: w_glyph = 7'b1101101;
      4'h6: w_glyph = 7'b1111101;
      4'h7: w_glyph = 7'b0000111;
      4'h8: w_glyph = 7'b1111111;
      4'h9: w_glyph = 7'b1101111;
      4'hA: w_glyph = 7'b1110111;
      4'hB: w_glyph = 7'b1111100;
      4'hC: w_glyph = 7'b0111001;
      4'hD: w_glyph = 7'b1011110;
      4'hE: w_glyph = 7'b1111001;
      4'hF: w_glyph = 7'b1110001;
      default: w_glyph = 7'b0000000;
    endcase
  end

  // Output assignment.
  // A "none" result blanks every digit and lights only the decimal point.
  assign bus.index    = r_index;
  assign bus.valid    = r_valid;
  assign bus.segments = r_none ? 7'b0000000 : w_glyph;
  assign bus.dp       = r_none;
  assign bus.digit_en = w_digit_en;

endmodule

// File: tb/tb_priority_scan_display.sv
// ----------------------------------------------------------------------------
// tb_priority_scan_display
//
// Purpose:
//   Directed testbench with two instances of priority_scan_display:
//     - dutA: WIDTH=16, PRESCALE=3, one display digit;
//     - dutB: WIDTH=32, PRESCALE=4, two display digits.
//   Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_priority_scan_display;

  logic clk;
  logic rstA;
  logic rstB;

  int nChecks = 0;
  int nFails  = 0;

  priority_scan_display_if #(.WIDTH(16)) busA ();
  priority_scan_display_if #(.WIDTH(32)) busB ();

  priority_scan_display #(.WIDTH(16), .PRESCALE(3)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA.slave)
  );

  priority_scan_display #(.WIDTH(32), .PRESCALE(4)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB.slave)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances past one rising edge.
  // Observation happens 1 ns after that edge.
  // Inputs changed afterwards are set up for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both instances in reset.
  // After reset: blank display, dp lit, digit 0 selected.
  task automatic test_reset();
    rstA = 1'b1;
    rstB = 1'b1;
    step();
    step();
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_A_result: index=%0d valid=%b, required index=0 valid=0",
               busA.index, busA.valid);
    end
    nChecks++;
    if (busA.segments !== 7'b0000000 || busA.dp !== 1'b1 || busA.digit_en !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_A_display: seg=%b dp=%b en=%b, required seg=0000000 dp=1 en=1",
               busA.segments, busA.dp, busA.digit_en);
    end
    nChecks++;
    if (busB.index !== 5'd0 || busB.valid !== 1'b0 || busB.segments !== 7'b0000000 ||
        busB.dp !== 1'b1 || busB.digit_en !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL reset_B: index=%0d valid=%b seg=%b dp=%b en=%b, required 0 0 0000000 1 01",
               busB.index, busB.valid, busB.segments, busB.dp, busB.digit_en);
    end
    rstA = 1'b0;
    rstB = 1'b0;
  endtask

  // Reset and sample asserted together with data 0xFFFF.
  // No capture may occur, so the result stays at "none".
  task automatic test_reset_priority();
    rstA        = 1'b1;
    busA.sample = 1'b1;
    busA.data   = 16'hFFFF;
    step();
    rstA        = 1'b0;
    busA.sample = 1'b0;
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b0 || busA.dp !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rst_prio_edge1: index=%0d valid=%b dp=%b, required 0 0 1",
               busA.index, busA.valid, busA.dp);
    end
    step();
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b0 || busA.dp !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rst_prio_edge2: index=%0d valid=%b dp=%b, required 0 0 1",
               busA.index, busA.valid, busA.dp);
    end
  endtask

  // A zero capture gives index 0, valid 0 and a blank display with dp lit.
  task automatic test_zero_data();
    busA.data   = 16'h0000;
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    step();
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b0 || busA.dp !== 1'b1 ||
        busA.segments !== 7'b0000000) begin
      nFails++;
      $display("[TB] FAIL zero_data: index=%0d valid=%b dp=%b seg=%b, required 0 0 1 0000000",
               busA.index, busA.valid, busA.dp, busA.segments);
    end
  endtask

  // Two-digit display on dutB, reset first so the scan phase is known.
  //   - 0x80000001, mode 0: index 0x1F, digit0 shows F, digit1 shows 1.
  //   - Same data, mode 1: index 0, digit1 shows 0.
  task automatic test_hex_display();
    rstB = 1'b1;
    step();
    rstB         = 1'b0;
    busB.data    = 32'h8000_0001;
    busB.mode    = 1'b0;
    busB.sample  = 1'b1;
    step();
    busB.sample  = 1'b0;
    step();
    nChecks++;
    if (busB.index !== 5'd31 || busB.valid !== 1'b1 || busB.dp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL hex_high_index: index=%0d valid=%b dp=%b, required 31 1 0",
               busB.index, busB.valid, busB.dp);
    end
    nChecks++;
    if (busB.digit_en !== 2'b01 || busB.segments !== 7'b1110001) begin
      nFails++;
      $display("[TB] FAIL hex_digit0: en=%b seg=%b, required en=01 seg=1110001",
               busB.digit_en, busB.segments);
    end
    step();
    step();
    nChecks++;
    if (busB.digit_en !== 2'b10 || busB.segments !== 7'b0000110) begin
      nFails++;
      $display("[TB] FAIL hex_digit1: en=%b seg=%b, required en=10 seg=0000110",
               busB.digit_en, busB.segments);
    end
    busB.mode   = 1'b1;
    busB.sample = 1'b1;
    step();
    busB.sample = 1'b0;
    step();
    nChecks++;
    if (busB.index !== 5'd0 || busB.valid !== 1'b1 || busB.dp !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL hex_low_index: index=%0d valid=%b dp=%b, required 0 1 0",
               busB.index, busB.valid, busB.dp);
    end
    nChecks++;
    if (busB.digit_en !== 2'b10 || busB.segments !== 7'b0111111) begin
      nFails++;
      $display("[TB] FAIL hex_low_digit1: en=%b seg=%b, required en=10 seg=0111111",
               busB.digit_en, busB.segments);
    end
    busB.mode = 1'b0;
  endtask

  // Hold behaviour on dutA.
  //   - Samples and data are ignored while hold is high.
  //   - A capture made the cycle before hold rises is still evaluated.
  task automatic test_hold();
    busA.mode   = 1'b0;
    busA.data   = 16'h0040;
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    step();
    nChecks++;
    if (busA.index !== 4'd6 || busA.valid !== 1'b1 || busA.segments !== 7'b1111101) begin
      nFails++;
      $display("[TB] FAIL hold_setup: index=%0d valid=%b seg=%b, required 6 1 1111101",
               busA.index, busA.valid, busA.segments);
    end
    busA.hold   = 1'b1;
    busA.data   = 16'h8000;
    busA.sample = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      nChecks++;
      if (busA.index !== 4'd6 || busA.valid !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL hold_cycle%0d: index=%0d valid=%b, required 6 1",
                 i, busA.index, busA.valid);
      end
    end
    busA.hold   = 1'b0;
    busA.sample = 1'b0;
    step();
    step();
    nChecks++;
    if (busA.index !== 4'd6) begin
      nFails++;
      $display("[TB] FAIL hold_release: index=%0d, required 6", busA.index);
    end
    busA.data   = 16'h0004;
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    busA.hold   = 1'b1;
    step();
    nChecks++;
    if (busA.index !== 4'd2 || busA.valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL hold_inflight: index=%0d valid=%b, required 2 1",
               busA.index, busA.valid);
    end
    busA.hold = 1'b0;
  endtask

  // Changing mode without sampling leaves the index untouched.
  // Sampling with mode 1 then selects the lowest set bit.
  task automatic test_mode_change();
    busA.mode   = 1'b0;
    busA.data   = 16'h0104;
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    step();
    nChecks++;
    if (busA.index !== 4'd8) begin
      nFails++;
      $display("[TB] FAIL mode_high: index=%0d, required 8", busA.index);
    end
    busA.mode = 1'b1;
    step();
    step();
    nChecks++;
    if (busA.index !== 4'd8) begin
      nFails++;
      $display("[TB] FAIL mode_no_sample: index=%0d, required 8", busA.index);
    end
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    step();
    nChecks++;
    if (busA.index !== 4'd2 || busA.valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mode_low: index=%0d valid=%b, required 2 1",
               busA.index, busA.valid);
    end
    busA.mode = 1'b0;
  endtask

  // Three consecutive samples must give three consecutive results.
  task automatic test_back_to_back();
    busA.mode   = 1'b0;
    busA.data   = 16'h0001;
    busA.sample = 1'b1;
    step();
    busA.data   = 16'h0100;
    step();
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL b2b_first: index=%0d valid=%b, required 0 1",
               busA.index, busA.valid);
    end
    busA.data   = 16'h8000;
    step();
    busA.sample = 1'b0;
    nChecks++;
    if (busA.index !== 4'd8) begin
      nFails++;
      $display("[TB] FAIL b2b_second: index=%0d, required 8", busA.index);
    end
    step();
    nChecks++;
    if (busA.index !== 4'd15 || busA.segments !== 7'b1110001) begin
      nFails++;
      $display("[TB] FAIL b2b_third: index=%0d seg=%b, required 15 1110001",
               busA.index, busA.segments);
    end
  endtask

  // A reset arriving while a capture awaits evaluation drops that capture.
  task automatic test_reset_inflight();
    busA.data   = 16'h00F0;
    busA.sample = 1'b1;
    step();
    busA.sample = 1'b0;
    rstA        = 1'b1;
    step();
    rstA        = 1'b0;
    step();
    nChecks++;
    if (busA.index !== 4'd0 || busA.valid !== 1'b0 || busA.dp !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rst_inflight: index=%0d valid=%b dp=%b, required 0 0 1",
               busA.index, busA.valid, busA.dp);
    end
  endtask

  // PRESCALE=4 on dutB.
  // After reset digit_en reads 01, 10, 01, each held for four cycles.
  // A single-digit dutA keeps digit_en at 1 throughout.
  task automatic test_prescale();
    logic [1:0] expEn;
    rstA = 1'b1;
    rstB = 1'b1;
    step();
    rstA = 1'b0;
    rstB = 1'b0;
    for (int i = 0; i < 12; i++) begin
      expEn = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
      nChecks++;
      if (busB.digit_en !== expEn) begin
        nFails++;
        $display("[TB] FAIL scan_cycle%0d: en=%b, required %b", i, busB.digit_en, expEn);
      end
      nChecks++;
      if (busA.digit_en !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL scan_single_cycle%0d: en=%b, required 1", i, busA.digit_en);
      end
      step();
    end
  endtask

  // Runs every scenario in sequence, then prints the summary.
  initial begin
    rstA        = 1'b1;
    rstB        = 1'b1;
    busA.data   = '0;
    busA.sample = 1'b0;
    busA.mode   = 1'b0;
    busA.hold   = 1'b0;
    busB.data   = '0;
    busB.sample = 1'b0;
    busB.mode   = 1'b0;
    busB.hold   = 1'b0;

    test_reset();
    test_reset_priority();
    test_zero_data();
    test_hex_display();
    test_hold();
    test_mode_change();
    test_back_to_back();
    test_reset_inflight();
    test_prescale();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
